// File: rtl/dsram_responder_pkg.sv
// dsram_responder_pkg: shared state encoding, default error data and memory bus widths
package dsram_responder_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/dsram_responder_if.sv
// dsram_responder_if: valid/grant request channel and rvalid response channel to memory
interface dsram_responder_if #(
    parameter int ADDR_W = dsram_responder_pkg::ADDR_W_DEF,
    parameter int DATA_W = dsram_responder_pkg::DATA_W_DEF
);

    logic                mem_req;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/dsram_timeout_ctr.sv
// dsram_timeout_ctr: counts cycles spent waiting for read data and flags the last allowed one
module dsram_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Cleared whenever the responder is not waiting, so every read starts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // High in the wait cycle whose increment brings the count to TIMEOUT
    assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dsram_responder.sv
// dsram_responder: turns core data-SRAM requests into single outstanding memory transfers with stall
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq_for_mem,
    output logic                err,
    dsram_responder_if.master   mem
);

    state_t state, state_nx;
    logic   accept, take, abort, expired, discard;

    assign accept           = (state == S_IDLE || state == S_DONE) && data_sram_en;
    assign take             = state == S_WAIT && mem.mem_rvalid && !discard;
    assign abort            = expired && !take;
    assign stallreq_for_mem = state == S_REQ || state == S_WAIT;
    assign mem.mem_req      = state == S_REQ;

    dsram_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != S_WAIT),
        .en      (state == S_WAIT),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Accept only in IDLE/DONE; posted writes skip WAIT; WAIT ends on data or timeout
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = accept ? S_REQ : S_IDLE;
            S_REQ:          state_nx = !mem.mem_gnt ? S_REQ : (mem.mem_we ? S_DONE : S_WAIT);
            S_WAIT:         state_nx = (take || expired) ? S_DONE : S_WAIT;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Request payload, load data, sticky error and the flag that swallows a stale response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.mem_we      <= 1'b0;
            mem.mem_be      <= '0;
            mem.mem_addr    <= '0;
            mem.mem_wdata   <= '0;
            data_sram_rdata <= '0;
            err             <= 1'b0;
            discard         <= 1'b0;
        end else begin
            if (accept) begin
                mem.mem_we    <= |data_sram_wen;
                mem.mem_be    <= (|data_sram_wen) ? data_sram_wen : '1;
                mem.mem_addr  <= data_sram_addr;
                mem.mem_wdata <= data_sram_wdata;
            end
            if (take)
                data_sram_rdata <= mem.mem_rdata;
            else if (abort)
                data_sram_rdata <= ERR_DATA;
            if (abort)
                err <= 1'b1;
            discard <= abort || (discard && !mem.mem_rvalid);
        end
    end

endmodule
